// File: rtl/if_types_pkg.sv
// Shared cache interface types: register offsets, operation codes and the
// register-bank <-> controller structs.
package if_types_pkg;

  localparam int AddressBits = 8;

  localparam logic [AddressBits-1:0] REG_DAT_LO_OFS = 8'h00;
  localparam logic [AddressBits-1:0] REG_DAT_HI_OFS = 8'h04;
  localparam logic [AddressBits-1:0] REG_KEY_OFS    = 8'h08;
  localparam logic [AddressBits-1:0] REG_CTR_OFS    = 8'h0C;

  typedef enum logic [2:0] {
    OP_NOOP   = 3'd0,
    OP_GET    = 3'd1,
    OP_SET    = 3'd2,
    OP_DEL    = 3'd3,
    OP_INCR   = 3'd4,
    OP_EXISTS = 3'd5,
    OP_EXPIRE = 3'd6,
    OP_FLUSH  = 3'd7
  } operation_e;

  typedef struct packed {
    logic [63:0] dat;
    logic [31:0] key;
    operation_e  operation;
  } reg_read_t;

  typedef struct packed {
    logic [63:0] dat;
    logic        dat_valid;
    logic        hit;
    logic        hit_valid;
    operation_e  operation;
    logic        operation_valid;
    logic        busy;
    logic        busy_valid;
  } reg_write_t;

endpackage

// File: rtl/redis_cache_regs_pkg.sv
// Local helpers for the cache register bank: CTR bit layout, word index and
// the per-byte write merge.
package redis_cache_regs_pkg;

  localparam int CTR_BUSY_BIT = 0;
  localparam int CTR_OP_LSB   = 1;
  localparam int CTR_OP_MSB   = 3;
  localparam int CTR_HIT_BIT  = 4;

  typedef enum logic [1:0] {WDAT_LO, WDAT_HI, WKEY, WCTR} word_idx_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_slave_ack.sv
// Wishbone-classic request detect and registered single-cycle ack; a held
// strobe therefore completes one transfer every two cycles.
module wb_slave_ack (
  input  logic clk,
  input  logic rst,
  input  logic cyc,
  input  logic stb,
  output logic req,
  output logic ack
);

  assign req = cyc & stb & ~ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack <= 1'b0;
    else     ack <= req;
  end

endmodule

// File: rtl/redis_cache_regs.sv
// Wishbone register bank for the Redis cache (DAT/KEY/CTR) with a per-field controller update port.
// Ack and read data are registered one cycle after the request; start_o pulses the cycle after a launch.
module redis_cache_regs
  import if_types_pkg::*;
  import redis_cache_regs_pkg::*;
#(
  parameter int                  AdrWidth = 32,
  parameter logic [AdrWidth-1:0] BaseAddr = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [AdrWidth-1:0] wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output reg_read_t           reg_o,
  input  reg_write_t          reg_i,
  output logic                start_o
);

  logic                     req;
  logic                     ack;
  logic [AddressBits-1:2]   ofs_word;
  logic                     base_ok;
  logic                     mapped;
  word_idx_e                widx;
  logic [63:0]              dat_q;
  logic [31:0]              key_q;
  operation_e               op_q;
  logic                     busy_q;
  logic                     hit_q;
  logic [31:0]              ctr_word;
  logic [31:0]              rdata;
  logic                     wr;
  logic                     rd;
  logic                     data_wr;
  logic                     launch;
  logic                     unused_adr;

  wb_slave_ack u_ack (
    .clk (clk_i),
    .rst (rst_i),
    .cyc (wb_cyc_i),
    .stb (wb_stb_i),
    .req (req),
    .ack (ack)
  );

  assign wb_ack_o   = ack;
  assign ofs_word   = wb_adr_i[AddressBits-1:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign base_ok    = (wb_adr_i[AdrWidth-1:AddressBits] == BaseAddr[AdrWidth-1:AddressBits]);

  always_comb begin
    widx   = WDAT_LO;
    mapped = base_ok;
    if      (ofs_word == REG_DAT_LO_OFS[AddressBits-1:2]) widx = WDAT_LO;
    else if (ofs_word == REG_DAT_HI_OFS[AddressBits-1:2]) widx = WDAT_HI;
    else if (ofs_word == REG_KEY_OFS[AddressBits-1:2])    widx = WKEY;
    else if (ofs_word == REG_CTR_OFS[AddressBits-1:2])    widx = WCTR;
    else                                                  mapped = 1'b0;
  end

  always_comb begin
    ctr_word                         = '0;
    ctr_word[CTR_BUSY_BIT]           = busy_q;
    ctr_word[CTR_OP_MSB:CTR_OP_LSB]  = op_q;
    ctr_word[CTR_HIT_BIT]            = hit_q;
    rdata = '0;
    if (mapped) begin
      case (widx)
        WDAT_LO: rdata = dat_q[31:0];
        WDAT_HI: rdata = dat_q[63:32];
        WKEY:    rdata = key_q;
        default: rdata = ctr_word;
      endcase
    end
  end

  assign wr      = req & wb_we_i & mapped;
  assign rd      = req & ~wb_we_i;
  assign data_wr = wr & ~busy_q;
  // busy is sampled before the controller update, so a same-cycle release still blocks the launch
  assign launch  = wr && (widx == WCTR) && wb_sel_i[0] && !busy_q
                   && (wb_dat_i[CTR_OP_MSB:CTR_OP_LSB] != OP_NOOP)
                   && !(reg_i.busy_valid && !reg_i.busy);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_dat_o <= '0;
      start_o  <= 1'b0;
      dat_q    <= '0;
      key_q    <= '0;
      op_q     <= OP_NOOP;
      busy_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      wb_dat_o <= rd ? rdata : '0;
      start_o  <= launch;

      if (reg_i.dat_valid)                    dat_q         <= reg_i.dat;
      else if (data_wr && (widx == WDAT_LO))  dat_q[31:0]   <= byte_merge(dat_q[31:0], wb_dat_i, wb_sel_i);
      else if (data_wr && (widx == WDAT_HI))  dat_q[63:32]  <= byte_merge(dat_q[63:32], wb_dat_i, wb_sel_i);

      if (data_wr && (widx == WKEY)) key_q <= byte_merge(key_q, wb_dat_i, wb_sel_i);

      if (reg_i.operation_valid) op_q <= reg_i.operation;
      else if (launch)           op_q <= operation_e'(wb_dat_i[CTR_OP_MSB:CTR_OP_LSB]);

      if (reg_i.busy_valid) busy_q <= reg_i.busy;
      else if (launch)      busy_q <= 1'b1;

      if (reg_i.hit_valid) hit_q <= reg_i.hit;
      else if (launch)     hit_q <= 1'b0;
    end
  end

  assign reg_o = '{dat: dat_q, key: key_q, operation: op_q};

endmodule

// File: tb/tb_redis_cache_regs.sv
// Self-checking bench for redis_cache_regs: directed scenarios plus randomized
// transfers checked against a byte-level behavioural model.
module tb_redis_cache_regs;
  import if_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic        start;
  reg_read_t   rro;
  reg_write_t  rwi = '0;

  always #5 clk = ~clk;

  redis_cache_regs #(.AdrWidth(32), .BaseAddr(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_ack_o(ack), .reg_o(rro), .reg_i(rwi), .start_o(start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_dat;
  logic [31:0] m_key;
  logic [2:0]  m_op;
  logic        m_busy;
  logic        m_hit;

  task automatic model_reset();
    m_dat = '0; m_key = '0; m_op = '0; m_busy = 1'b0; m_hit = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:8] != 24'd0 || a[7:0] >= 8'h10) return 32'd0;
    case (a[3:2])
      2'd0:    return m_dat[31:0];
      2'd1:    return m_dat[63:32];
      2'd2:    return m_key;
      default: return {27'd0, m_hit, m_op, m_busy};
    endcase
  endfunction

  // The 12 data bytes (DAT lo, DAT hi, KEY) form one byte-addressed store.
  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input reg_write_t cw,
                            output logic [31:0] e_rd, output logic e_st);
    logic        mapped;
    logic [95:0] store;
    logic [2:0]  n_op;
    logic        n_busy, n_hit;
    int          word;
    mapped = (a[31:8] == 24'd0) && (a[7:0] < 8'h10);
    word   = int'(a[3:2]);
    e_rd   = w ? 32'd0 : model_read(a);
    e_st   = 1'b0;
    store  = {m_key, m_dat};
    n_op = m_op; n_busy = m_busy; n_hit = m_hit;
    if (w && mapped) begin
      if (word != 3) begin
        if (!m_busy)
          for (int b = 0; b < 4; b++)
            if (s[b]) store[(word*4 + b)*8 +: 8] = d[b*8 +: 8];
      end else if (s[0] && !m_busy && d[3:1] != 3'd0 && !(cw.busy_valid && !cw.busy)) begin
        e_st = 1'b1; n_op = d[3:1]; n_busy = 1'b1; n_hit = 1'b0;
      end
    end
    m_dat  = cw.dat_valid       ? cw.dat       : store[63:0];
    m_key  = store[95:64];
    m_op   = cw.operation_valid ? cw.operation : n_op;
    m_busy = cw.busy_valid      ? cw.busy      : n_busy;
    m_hit  = cw.hit_valid       ? cw.hit       : n_hit;
  endtask

  // One bus transfer. hs = {ack after req edge, ack one cycle later, start after req edge, start one cycle later}
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input reg_write_t cw, output logic [3:0] hs, output logic [31:0] rd,
                      output logic e_st, output logic [31:0] e_rd);
    model_step(w, a, d, s, cw, e_rd, e_st);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; rwi = cw;
    @(posedge clk); #1;
    hs[3] = ack; hs[1] = start; rd = rdat; rwi = '0;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    hs[2] = ack; hs[0] = start;
  endtask

  task automatic test_reset();
    logic [3:0] hs; logic [31:0] rd, er; logic es;
    reg_write_t z = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack, start, rdat, rro} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: ack=%b start=%b dat=%h reg_o=%h, required all 0", ack, start, rdat, rro);
    end
    rst = 1'b0;
    xact(1'b1, 32'h0, 32'h12345678, 4'hF, z, hs, rd, es, er);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC; wdat = 32'h2; sel = 4'h1;
    @(posedge clk); #1;
    n_checks++;
    if ({ack, start} !== 2'b11) begin
      n_fail++; $display("FAIL reset_prelaunch: ack,start=%b required 11", {ack, start});
    end
    rst = 1'b1; #1;
    n_checks++;
    if ({ack, start, rdat, rro} !== '0) begin
      n_fail++; $display("FAIL reset_async: ack=%b start=%b dat=%h reg_o=%h, required all 0", ack, start, rdat, rro);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    model_reset();
    xact(1'b0, 32'hC, 32'h0, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (hs[3] !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_ctr_read: ack=%b ctr=%h, required ack=1 ctr=0", hs[3], rd);
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] vals  [3] = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D};
    logic [3:0] hs; logic [31:0] rd, er; logic es;
    reg_write_t z = '0;
    for (int i = 0; i < 3; i++) begin
      xact(1'b1, addrs[i], vals[i], 4'hF, z, hs, rd, es, er);
      n_checks++;
      if (hs !== 4'b1000) begin
        n_fail++; $display("FAIL rw_write_ack[%0d]: handshake=%b required 1000", i, hs);
      end
    end
    n_checks++;
    if (rro.dat !== 64'h01234567DEADBEEF || rro.key !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rw_reg_o: dat=%h key=%h required 01234567deadbeef cafef00d", rro.dat, rro.key);
    end
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, addrs[i], 32'h0, 4'hF, z, hs, rd, es, er);
      n_checks++;
      if (hs[3:2] !== 2'b10 || rd !== vals[i]) begin
        n_fail++; $display("FAIL rw_readback[%0d]: ack=%b data=%h required 10 %h", i, hs[3:2], rd, vals[i]);
      end
    end
  endtask

  task automatic test_byte_enables();
    logic [3:0] hs; logic [31:0] rd, er; logic es;
    reg_write_t z = '0;
    xact(1'b1, 32'h8, 32'h0, 4'hF, z, hs, rd, es, er);
    xact(1'b1, 32'h8, 32'hAABBCCDD, 4'b0010, z, hs, rd, es, er);
    n_checks++;
    if (rro.key !== 32'h0000CC00) begin
      n_fail++; $display("FAIL byte_enable_key: key=%h required 0000cc00", rro.key);
    end
  endtask

  task automatic test_launch();
    logic [3:0] hs; logic [31:0] rd, er; logic es;
    reg_write_t z = '0;
    xact(1'b1, 32'hC, {28'd0, OP_GET, 1'b0}, 4'h1, z, hs, rd, es, er);
    n_checks++;
    if (hs !== 4'b1010) begin
      n_fail++; $display("FAIL launch_start: handshake=%b required 1010", hs);
    end
    xact(1'b0, 32'hC, 32'h0, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (rd !== 32'h3) begin
      n_fail++; $display("FAIL launch_ctr: ctr=%h required 00000003", rd);
    end
    xact(1'b1, 32'hC, {28'd0, OP_SET, 1'b0}, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (hs[1:0] !== 2'b00 || rro.operation !== OP_GET) begin
      n_fail++; $display("FAIL launch_while_busy: start=%b op=%0d required 00 op=1", hs[1:0], rro.operation);
    end
    xact(1'b1, 32'h0, 32'h11111111, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (rro.dat !== 64'h01234567DEADBEEF) begin
      n_fail++; $display("FAIL dat_while_busy: dat=%h required 01234567deadbeef", rro.dat);
    end
  endtask

  task automatic test_completion();
    logic [3:0] hs; logic [31:0] rd, er; logic es;
    reg_write_t z = '0;
    reg_write_t cw = '0;
    cw.busy_valid = 1'b1; cw.busy = 1'b0;
    cw.hit_valid  = 1'b1; cw.hit  = 1'b1;
    cw.dat_valid  = 1'b1; cw.dat  = 64'h55;
    xact(1'b0, 32'hC, 32'h0, 4'hF, cw, hs, rd, es, er);
    xact(1'b0, 32'hC, 32'h0, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (rd !== 32'h12) begin
      n_fail++; $display("FAIL completion_ctr: ctr=%h required 00000012", rd);
    end
    xact(1'b0, 32'h0, 32'h0, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (rd !== 32'h55) begin
      n_fail++; $display("FAIL completion_dat: dat_lo=%h required 00000055", rd);
    end
    cw = '0; cw.dat_valid = 1'b1; cw.dat = 64'h77;
    xact(1'b1, 32'h0, 32'h99999999, 4'hF, cw, hs, rd, es, er);
    n_checks++;
    if (rro.dat !== 64'h77) begin
      n_fail++; $display("FAIL ctrl_wins_dat: dat=%h required 0000000000000077", rro.dat);
    end
    cw = '0; cw.busy_valid = 1'b1; cw.busy = 1'b0;
    xact(1'b1, 32'hC, {28'd0, OP_DEL, 1'b0}, 4'h1, cw, hs, rd, es, er);
    n_checks++;
    if (hs[1] !== 1'b0 || rro.operation !== OP_GET) begin
      n_fail++; $display("FAIL launch_vs_release: start=%b op=%0d required 0 op=1", hs[1], rro.operation);
    end
  endtask

  task automatic test_unmapped();
    logic [3:0] hs; logic [31:0] rd, er; logic es;
    reg_read_t snap;
    reg_write_t z = '0;
    xact(1'b0, 32'h10, 32'h0, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (hs[3] !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: ack=%b data=%h required 1 00000000", hs[3], rd);
    end
    snap = rro;
    xact(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, z, hs, rd, es, er);
    xact(1'b1, 32'h10C, {28'd0, OP_SET, 1'b0}, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (rro !== snap || hs[1] !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_write: reg_o=%h start=%b required %h 0", rro, hs[1], snap);
    end
    xact(1'b0, 32'h108, 32'h0, 4'hF, z, hs, rd, es, er);
    n_checks++;
    if (hs[3] !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL base_mismatch_read: ack=%b data=%h required 1 00000000", hs[3], rd);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 2 == 0);
      n_checks++;
      if (ack !== exp_ack || (exp_ack && rdat !== m_key)) begin
        n_fail++; $display("FAIL back_to_back[%0d]: ack=%b data=%h required %b %h", i, ack, rdat, exp_ack, m_key);
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] hs; logic [31:0] rd, er, a, d; logic es, w;
    reg_write_t cw;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 2)) * 4 + 32'($urandom_range(0, 3));
        5, 6:          a = 32'hC;
        7:             a = 32'h10 + 32'($urandom_range(0, 8'hEF));
        default:       a = 32'h100 | 32'($urandom_range(0, 15));
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      cw = '0;
      if ($urandom_range(0, 3) == 0) begin
        cw.dat_valid       = 1'($urandom_range(0, 1));
        cw.dat             = {$urandom, $urandom};
        cw.hit_valid       = 1'($urandom_range(0, 1));
        cw.hit             = 1'($urandom_range(0, 1));
        cw.operation_valid = 1'($urandom_range(0, 1));
        cw.operation       = operation_e'(3'($urandom_range(0, 7)));
        cw.busy_valid      = 1'($urandom_range(0, 1));
        cw.busy            = 1'($urandom_range(0, 1));
      end
      xact(w, a, d, 4'($urandom_range(0, 15)), cw, hs, rd, es, er);
      n_checks++;
      if (hs !== {2'b10, es, 1'b0}) begin
        n_fail++; $display("FAIL rand_handshake[%0d]: %b required %b", i, hs, {2'b10, es, 1'b0});
      end
      n_checks++;
      if (!w && rd !== er) begin
        n_fail++; $display("FAIL rand_read[%0d] @%h: %h required %h", i, a, rd, er);
      end
      n_checks++;
      if ({rro.dat, rro.key, rro.operation} !== {m_dat, m_key, m_op}) begin
        n_fail++; $display("FAIL rand_reg_o[%0d]: %h required %h", i, {rro.dat, rro.key, rro.operation}, {m_dat, m_key, m_op});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_enables();
    test_launch();
    test_completion();
    test_unmapped();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
